spike_event_collector: RTL

SPIKE_EVENT_COLLECTOR -- requirements
Module: spike_event_collector

---
 rtl/spike_collector_pkg.sv | 15 +
 rtl/spike_event_collector_if.sv | 29 ++
 rtl/spike_addr_fifo.sv | 55 +++++
 rtl/spike_event_collector.sv | 98 +++++++++
 4 files changed

// File: rtl/spike_collector_pkg.sv
// rtl/spike_collector_pkg.sv - shared types and constants for the spike event collector
// Contents: collector state enum, spike counter width, default FIFO depth.
package spike_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int COUNT_W       = 16;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/spike_event_collector_if.sv
// rtl/spike_event_collector_if.sv - spike strobe input and host read handshake bundle
// Signals:
//   spike_pushback_i       strobe from the upstream pushback stage
//   spike_pushback_addr_i  spiking neuron address (valid with the strobe)
//   rd_ready_i             host accepts the head entry
//   rd_valid_o             FIFO head is valid
//   rd_addr_o              FIFO head neuron address
// Modports: master = upstream/host side, slave = collector side.
interface spike_event_collector_if #(
  parameter int N = 256
);
  localparam int AW = $clog2(N);

  logic          spike_pushback_i;
  logic [AW-1:0] spike_pushback_addr_i;
  logic          rd_ready_i;
  logic          rd_valid_o;
  logic [AW-1:0] rd_addr_o;

  modport master (
    output spike_pushback_i, spike_pushback_addr_i, rd_ready_i,
    input  rd_valid_o, rd_addr_o
  );

  modport slave (
    input  spike_pushback_i, spike_pushback_addr_i, rd_ready_i,
    output rd_valid_o, rd_addr_o
  );
endinterface

// File: rtl/spike_addr_fifo.sv
// rtl/spike_addr_fifo.sv - first-word-fall-through flop-array FIFO of neuron addresses
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush            empties the FIFO on the next edge
//   push, wr_data    write request and data
//   pop              read request (head advances on the edge)
//   rd_data          current head entry (combinational)
//   full, empty      occupancy flags
module spike_addr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // A write into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spike_event_collector.sv
// rtl/spike_event_collector.sv - collects output-spike addresses of one inference for host readout
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            pulse starting a new collection (flushes FIFO, clears count/overflow)
//   inference_done_i   end of inference from upstream (honoured only while collecting)
//   bus                spike strobe in, FIFO head read handshake out
//   spike_count_o      saturating spike count for this inference
//   overflow_o         sticky: a spike was dropped on a full FIFO
//   busy_o, done_o     status levels; irq_o pulses on the first DONE cycle
module spike_event_collector
  import spike_collector_pkg::*;
#(
  parameter int N     = 256,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   inference_done_i,
  spike_event_collector_if.slave bus,
  output logic [COUNT_W-1:0]     spike_count_o,
  output logic                   overflow_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   irq_o
);
  localparam int AW = $clog2(N);

  state_t        state;
  state_t        state_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          strobe;
  logic          push;
  logic [AW-1:0] fifo_rd_data;

  // start_i wins over a same-cycle strobe, so no spike is counted or stored then.
  assign strobe = (state == ST_COLLECT) && bus.spike_pushback_i && !start_i;
  assign pop    = !fifo_empty && bus.rd_ready_i;
  assign push   = strobe && (!fifo_full || pop);

  spike_addr_fifo #(
    .W    (AW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush  (start_i),
    .push   (push),
    .pop    (pop),
    .wr_data(bus.spike_pushback_addr_i),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.rd_valid_o = !fifo_empty;
  // Mask the unreset storage so the address output reads zero when nothing is buffered.
  assign bus.rd_addr_o  = fifo_empty ? '0 : fifo_rd_data;
  assign busy_o         = (state == ST_COLLECT) || (state == ST_DRAIN);
  assign done_o         = (state == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_i) begin
      state_next = ST_COLLECT;
    end else begin
      unique case (state)
        ST_COLLECT: if (inference_done_i) state_next = ST_DRAIN;
        ST_DRAIN:   if (fifo_empty)       state_next = ST_DONE;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      spike_count_o <= '0;
      overflow_o    <= 1'b0;
    end else if (strobe) begin
      if (spike_count_o != '1) spike_count_o <= spike_count_o + 1'b1;
      if (fifo_full && !pop)   overflow_o    <= 1'b1;
    end
  end

  // Registered so the pulse lines up with the first cycle done_o is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= (state_next == ST_DONE) && (state != ST_DONE);
  end

endmodule
